// File: rtl/idu_issue_sequencer.sv
// idu_issue_sequencer: fetch -> decode -> issue handshake sequencer with a
// 32-entry register scoreboard, forwarding selection and sticky halt.
module idu_issue_sequencer #(
    parameter int DEC_TIMEOUT  = 8,
    parameter int MAX_INFLIGHT = 4,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   soc_clk,
    input  logic                   reset,
    input  logic                   fetch_valid,
    input  logic [31:0]            fetch_instr,
    output logic                   fetch_ready,
    output logic                   dec_start,
    output logic [31:0]            dec_instr,
    input  logic                   dec_done,
    input  logic [4:0]             dec_rd,
    input  logic [4:0]             dec_rs1,
    input  logic [4:0]             dec_rs2,
    input  logic                   dec_use_rs1,
    input  logic                   dec_use_rs2,
    input  logic                   dec_wr_rd,
    input  logic                   dec_invalid,
    input  logic                   dec_halt,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [1:0]             issue_fwd,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_rd,
    output logic                   halted,
    output logic [1:0]             halt_cause,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_STALL  = 3'd3,
        ST_ISSUE  = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    localparam int                     TMO_W         = $clog2(DEC_TIMEOUT);
    localparam logic [TMO_W-1:0]       TMO_LAST      = TMO_W'(DEC_TIMEOUT - 1);
    localparam logic [TMO_W-1:0]       TMO_ONE       = TMO_W'(1);
    localparam logic [3:0]             MAX_INFL      = 4'(MAX_INFLIGHT);
    localparam logic [STALL_CNT_W-1:0] STALL_SAT     = {STALL_CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] STALL_ONE     = STALL_CNT_W'(1);
    localparam logic [1:0]             CAUSE_INVALID = 2'b01;
    localparam logic [1:0]             CAUSE_ECALL   = 2'b10;
    localparam logic [1:0]             CAUSE_TIMEOUT = 2'b11;

    // x0 is excluded here so it can never stall or forward.
    function automatic logic hazard_f(input logic use_i, input logic [4:0] rs_i,
                                      input logic [31:0] busy_i);
        return use_i && (rs_i != 5'd0) && busy_i[rs_i];
    endfunction

    state_e                 state_q, state_d;
    logic [31:0]            busy_q, busy_d;
    logic [3:0]             inflight_q, inflight_d;
    logic [4:0]             last_rd_q, last_rd_d;
    logic [TMO_W-1:0]       dec_cnt_q, dec_cnt_d;
    logic [4:0]             rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic                   use_rs1_q, use_rs1_d, use_rs2_q, use_rs2_d;
    logic                   wr_rd_q, wr_rd_d;
    logic                   fetch_ready_q, fetch_ready_d;
    logic                   dec_start_q, dec_start_d;
    logic [31:0]            dec_instr_q, dec_instr_d;
    logic                   issue_valid_q, issue_valid_d;
    logic [1:0]             issue_fwd_q, issue_fwd_d;
    logic                   halted_q, halted_d;
    logic [1:0]             halt_cause_q, halt_cause_d;
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

    logic                   hz1_s, hz2_s, fwd1_s, fwd2_s, stall_s;
    logic                   issue_hs_s, wb_clr_s, iss_set_s;
    logic [31:0]            clr_mask_s, set_mask_s;

    // Hazard and forwarding evaluation on the captured decode fields
    always_comb begin
        hz1_s   = hazard_f(use_rs1_q, rs1_q, busy_q);
        hz2_s   = hazard_f(use_rs2_q, rs2_q, busy_q);
        fwd1_s  = hz1_s && (rs1_q == last_rd_q);
        fwd2_s  = hz2_s && (rs2_q == last_rd_q);
        stall_s = (hz1_s && !fwd1_s) || (hz2_s && !fwd2_s) ||
                  (wr_rd_q && (inflight_q == MAX_INFL));
    end

    // Scoreboard bookkeeping: writeback clears, issue sets (set wins on collision)
    always_comb begin
        issue_hs_s = (state_q == ST_ISSUE) && issue_valid_q && issue_ready;
        wb_clr_s   = wb_valid && (wb_rd != 5'd0) && busy_q[wb_rd];
        iss_set_s  = issue_hs_s && wr_rd_q && (rd_q != 5'd0);
        clr_mask_s = wb_clr_s  ? (32'd1 << wb_rd) : 32'd0;
        set_mask_s = iss_set_s ? (32'd1 << rd_q)  : 32'd0;
        busy_d     = ((busy_q & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
        case ({iss_set_s, wb_clr_s})
            2'b10:   inflight_d = (inflight_q != 4'hF) ? inflight_q + 4'd1 : inflight_q;
            2'b01:   inflight_d = (inflight_q != 4'h0) ? inflight_q - 4'd1 : inflight_q;
            default: inflight_d = inflight_q;
        endcase
        last_rd_d     = iss_set_s ? rd_q : last_rd_q;
        stall_count_d = ((state_q == ST_STALL) && (stall_count_q != STALL_SAT)) ?
                        stall_count_q + STALL_ONE : stall_count_q;
    end

    // Sequencer next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        dec_instr_d  = dec_instr_q;
        dec_cnt_d    = dec_cnt_q;
        rd_d         = rd_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        use_rs1_d    = use_rs1_q;
        use_rs2_d    = use_rs2_q;
        wr_rd_d      = wr_rd_q;
        issue_fwd_d  = issue_fwd_q;
        halt_cause_d = halt_cause_q;
        case (state_q)
            ST_IDLE: begin
                if (fetch_valid && fetch_ready_q) begin
                    dec_instr_d = fetch_instr;
                    dec_cnt_d   = {TMO_W{1'b0}};
                    state_d     = ST_DECODE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (dec_done) begin
                    rd_d      = dec_rd;
                    rs1_d     = dec_rs1;
                    rs2_d     = dec_rs2;
                    use_rs1_d = dec_use_rs1;
                    use_rs2_d = dec_use_rs2;
                    wr_rd_d   = dec_wr_rd;
                    if (dec_invalid) begin
                        state_d      = ST_HALT;
                        halt_cause_d = CAUSE_INVALID;
                    end else if (dec_halt) begin
                        state_d      = ST_HALT;
                        halt_cause_d = CAUSE_ECALL;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end else if (dec_cnt_q == TMO_LAST) begin
                    state_d      = ST_HALT;
                    halt_cause_d = CAUSE_TIMEOUT;
                end else begin
                    dec_cnt_d = dec_cnt_q + TMO_ONE;
                end
            end
            ST_CHECK, ST_STALL: begin
                if (stall_s) begin
                    state_d = ST_STALL;
                end else begin
                    state_d     = ST_ISSUE;
                    issue_fwd_d = {fwd2_s, fwd1_s};
                end
            end
            ST_ISSUE: begin
                if (issue_hs_s) begin
                    state_d     = ST_IDLE;
                    issue_fwd_d = 2'b00;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
        fetch_ready_d = (state_d == ST_IDLE);
        dec_start_d   = (state_d == ST_DECODE) && (state_q == ST_IDLE);
        issue_valid_d = (state_d == ST_ISSUE);
        halted_d      = (state_d == ST_HALT);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge soc_clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            busy_q        <= 32'd0;
            inflight_q    <= 4'd0;
            last_rd_q     <= 5'd0;
            dec_cnt_q     <= {TMO_W{1'b0}};
            rd_q          <= 5'd0;
            rs1_q         <= 5'd0;
            rs2_q         <= 5'd0;
            use_rs1_q     <= 1'b0;
            use_rs2_q     <= 1'b0;
            wr_rd_q       <= 1'b0;
            fetch_ready_q <= 1'b0;
            dec_start_q   <= 1'b0;
            dec_instr_q   <= 32'd0;
            issue_valid_q <= 1'b0;
            issue_fwd_q   <= 2'b00;
            halted_q      <= 1'b0;
            halt_cause_q  <= 2'b00;
            stall_count_q <= {STALL_CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            inflight_q    <= inflight_d;
            last_rd_q     <= last_rd_d;
            dec_cnt_q     <= dec_cnt_d;
            rd_q          <= rd_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            use_rs1_q     <= use_rs1_d;
            use_rs2_q     <= use_rs2_d;
            wr_rd_q       <= wr_rd_d;
            fetch_ready_q <= fetch_ready_d;
            dec_start_q   <= dec_start_d;
            dec_instr_q   <= dec_instr_d;
            issue_valid_q <= issue_valid_d;
            issue_fwd_q   <= issue_fwd_d;
            halted_q      <= halted_d;
            halt_cause_q  <= halt_cause_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_ready = fetch_ready_q;
    assign dec_start   = dec_start_q;
    assign dec_instr   = dec_instr_q;
    assign issue_valid = issue_valid_q;
    assign issue_fwd   = issue_fwd_q;
    assign halted      = halted_q;
    assign halt_cause  = halt_cause_q;
    assign stall_count = stall_count_q;

endmodule
